// File: rtl/fft_output_reorder_pkg.sv
// Shared types for the FFT output reorder buffer: FSM states, sample struct and sizing.
package fft_output_reorder_pkg;

  localparam int bit_width = 24;
  localparam int N         = 16;
  localparam int SIZE      = $clog2(N);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  typedef struct packed {
    logic [bit_width-1:0] re;
    logic [bit_width-1:0] im;
  } cplx_t;

endpackage

// File: rtl/fft_output_reorder_if.sv
// Stream bundle: unthrottled scattered input from the last butterfly stage,
// valid/ready natural-order output, and status flags.
interface fft_output_reorder_if;
  import fft_output_reorder_pkg::*;

  logic                 valid_i;
  logic [bit_width-1:0] Re_i;
  logic [bit_width-1:0] Im_i;
  logic [SIZE-1:0]      wr_ptr_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [bit_width-1:0] Re_o;
  logic [bit_width-1:0] Im_o;
  logic [SIZE-1:0]      idx_o;
  logic                 last_o;
  logic                 frame_done_o;
  logic                 dup_err_o;
  logic                 drop_err_o;

  modport slave (
    input  valid_i, Re_i, Im_i, wr_ptr_i, ready_i,
    output valid_o, Re_o, Im_o, idx_o, last_o, frame_done_o, dup_err_o, drop_err_o
  );

  modport master (
    output valid_i, Re_i, Im_i, wr_ptr_i, ready_i,
    input  valid_o, Re_o, Im_o, idx_o, last_o, frame_done_o, dup_err_o, drop_err_o
  );

endinterface

// File: rtl/fft_output_reorder_out_skid_reg.sv
// Single-entry valid/ready output register; holds data, idx and last stable while stalled.
module out_skid_reg
  import fft_output_reorder_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  cplx_t           data,
  input  logic [SIZE-1:0] idx,
  input  logic            last,
  input  logic            ready,
  output logic            valid,
  output cplx_t           q_data,
  output logic [SIZE-1:0] q_idx,
  output logic            q_last
);

  // Output beat register: a load wins, otherwise an accepted beat empties the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      q_data <= '{re: {bit_width{1'b0}}, im: {bit_width{1'b0}}};
      q_idx  <= {SIZE{1'b0}};
      q_last <= 1'b0;
    end else if (load) begin
      valid  <= 1'b1;
      q_data <= data;
      q_idx  <= idx;
      q_last <= last;
    end else if (valid && ready) begin
      valid  <= 1'b0;
    end else begin
      valid  <= valid;
    end
  end

endmodule

// File: rtl/fft_output_reorder.sv
// Gathers bit-scattered FFT bins into a buffer and drains them in natural order
// once every bin of the frame has arrived.
module fft_output_reorder
  import fft_output_reorder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  fft_output_reorder_if.slave  bus
);

  localparam logic [SIZE:0]   N_CNT = (SIZE+1)'(N);
  localparam logic [SIZE-1:0] LAST_IDX = SIZE'(N - 1);

  state_e          state_r;
  logic [N-1:0]    filled_r;
  logic [SIZE:0]   fill_cnt_r;
  logic [SIZE:0]   rd_ptr_r;
  logic            frame_done_r;
  logic            dup_err_r;
  logic            drop_err_r;
  cplx_t           mem_r [N];

  logic            load_s;
  logic            final_s;
  logic            wr_en_s;
  logic            sk_valid_s;
  cplx_t           sk_data_s;
  logic [SIZE-1:0] sk_idx_s;
  logic            sk_last_s;

  // Drain-side handshake decode and fill-side write enable.
  always_comb begin
    load_s  = 1'b0;
    final_s = 1'b0;
    wr_en_s = 1'b0;
    if (state_r == DRAIN) begin
      load_s  = (!sk_valid_s || bus.ready_i) && (rd_ptr_r < N_CNT);
      final_s = sk_valid_s && bus.ready_i && sk_last_s;
    end else begin
      wr_en_s = bus.valid_i;
    end
  end

  // Sample buffer; contents are don't-care after reset since the bitmap gates them.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[bus.wr_ptr_i] <= {bus.Re_i, bus.Im_i};
    end else begin
      mem_r[bus.wr_ptr_i] <= mem_r[bus.wr_ptr_i];
    end
  end

  // Frame FSM with fill bitmap, counter, read pointer and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= FILL;
      filled_r     <= {N{1'b0}};
      fill_cnt_r   <= {(SIZE+1){1'b0}};
      rd_ptr_r     <= {(SIZE+1){1'b0}};
      frame_done_r <= 1'b0;
      dup_err_r    <= 1'b0;
      drop_err_r   <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        FILL: begin
          if (bus.valid_i) begin
            if (filled_r[bus.wr_ptr_i]) begin
              dup_err_r <= 1'b1;
            end else begin
              filled_r[bus.wr_ptr_i] <= 1'b1;
              fill_cnt_r             <= fill_cnt_r + (SIZE+1)'(1);
              if (fill_cnt_r == N_CNT - (SIZE+1)'(1)) begin
                state_r  <= DRAIN;
                rd_ptr_r <= {(SIZE+1){1'b0}};
              end
            end
          end
        end
        DRAIN: begin
          // Upstream cannot be stalled, so anything arriving now is lost.
          if (bus.valid_i) begin
            drop_err_r <= 1'b1;
          end
          if (load_s) begin
            rd_ptr_r <= rd_ptr_r + (SIZE+1)'(1);
          end
          if (final_s) begin
            frame_done_r <= 1'b1;
            filled_r     <= {N{1'b0}};
            fill_cnt_r   <= {(SIZE+1){1'b0}};
            state_r      <= FILL;
          end
        end
        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

  out_skid_reg u_out (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .data   (mem_r[rd_ptr_r[SIZE-1:0]]),
    .idx    (rd_ptr_r[SIZE-1:0]),
    .last   (rd_ptr_r[SIZE-1:0] == LAST_IDX),
    .ready  (bus.ready_i),
    .valid  (sk_valid_s),
    .q_data (sk_data_s),
    .q_idx  (sk_idx_s),
    .q_last (sk_last_s)
  );

  assign bus.valid_o      = sk_valid_s;
  assign bus.Re_o         = sk_data_s.re;
  assign bus.Im_o         = sk_data_s.im;
  assign bus.idx_o        = sk_idx_s;
  assign bus.last_o       = sk_last_s;
  assign bus.frame_done_o = frame_done_r;
  assign bus.dup_err_o    = dup_err_r;
  assign bus.drop_err_o   = drop_err_r;

endmodule

// File: tb/tb_fft_output_reorder.sv
// Scoreboard bench: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_fft_output_reorder;

  typedef struct packed {
    logic [23:0] re;
    logic [23:0] im;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fft_output_reorder_if bus();

  fft_output_reorder dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_drive_cyc = 0;
  int    first_due = 0;
  int    first_cyc = 0;
  int    last_cyc = 0;
  int    beat_cnt = 0;
  bit    expect_done = 1'b0;
  bit    ready_mode = 1'b0;
  beat_t exp_q[$];
  int    brev[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ready generator: always high, or the 1,0,0,1 stall pattern.
  initial begin
    int ph = 0;
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode) begin
        bus.ready_i = (ph == 0 || ph == 3);
        ph = (ph + 1) % 4;
      end else begin
        bus.ready_i = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor: compares accepted beats, stall stability and frame_done timing.
  initial begin
    bit    prev_stall = 1'b0;
    beat_t prev;
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          chk("hold_stable", {bus.valid_o, bus.Re_o, bus.Im_o, bus.idx_o, bus.last_o},
              {1'b1, prev.re, prev.im, prev.idx, prev.last});
        if (expect_done) begin
          chk("frame_done", 64'(bus.frame_done_o), 64'd1);
          expect_done = 1'b0;
        end else if (bus.frame_done_o) begin
          chk("frame_done_unexpected", 64'(bus.frame_done_o), 64'd0);
        end
        if (bus.valid_o && bus.ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat_idx", 64'(bus.idx_o), 64'hFFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {bus.Re_o, bus.Im_o, bus.idx_o, bus.last_o},
                {e.re, e.im, e.idx, e.last});
            if (first_due != 0 && e.idx == 4'd0) begin
              chk("first_latency", 64'(cyc), 64'(first_due));
              first_due = 0;
            end
            if (e.idx == 4'd0) first_cyc = cyc;
            if (e.idx == 4'd15) last_cyc = cyc;
            if (e.last) expect_done = 1'b1;
            beat_cnt++;
          end
        end
        prev_stall = bus.valid_o && !bus.ready_i;
        prev = '{re: bus.Re_o, im: bus.Im_o, idx: bus.idx_o, last: bus.last_o};
      end
    end
  end

  task automatic write(input int bin, input int re, input int im);
    @(posedge clk);
    #1;
    bus.valid_i  = 1'b1;
    bus.wr_ptr_i = 4'(bin);
    bus.Re_i     = 24'(re);
    bus.Im_i     = 24'(im);
    last_drive_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.valid_i = 1'b0;
    end
  endtask

  // Expected natural-order frame: Re=k*100+off, Im=-(k+off); optional bin-3 override of 9/-9.
  task automatic push_frame(input int off, input bit dup3, input bit timed);
    beat_t b;
    for (int k = 0; k < 16; k++) begin
      b.re   = (dup3 && k == 3) ? 24'd9 : 24'(k * 100 + off);
      b.im   = (dup3 && k == 3) ? 24'(-9) : 24'(-(k + off));
      b.idx  = 4'(k);
      b.last = (k == 15);
      exp_q.push_back(b);
    end
    if (timed) first_due = last_drive_cyc + 2;
  endtask

  task automatic fill_frame(input int off, input bit timed);
    for (int j = 0; j < 16; j++) write(brev[j], brev[j] * 100 + off, -(brev[j] + off));
    push_frame(off, 1'b0, timed);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || expect_done) && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (n >= 300) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.frame_done_o && n < 300);
    if (n >= 300) chk("done_timeout", 64'(bus.frame_done_o), 64'd1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {bus.valid_o, bus.Re_o, bus.Im_o, bus.idx_o, bus.last_o,
               bus.frame_done_o, bus.dup_err_o, bus.drop_err_o}, 64'd0);
  endtask

  initial begin
    int n;
    bus.valid_i = 1'b0; bus.Re_i = 24'd0; bus.Im_i = 24'd0; bus.wr_ptr_i = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset_state");
    rst = 1'b0;

    // Bit-reversed fill, ready always high.
    fill_frame(0, 1'b1);
    idle(1);
    wait_drain();
    chk("consecutive_beats", 64'(last_cyc - first_cyc), 64'd15);
    chk("errs_after_t1", {bus.dup_err_o, bus.drop_err_o}, 64'd0);

    // Backpressure with ready pattern 1,0,0,1.
    ready_mode = 1'b1;
    fill_frame(0, 1'b0);
    idle(1);
    wait_drain();
    ready_mode = 1'b0;

    // Duplicate write of bin 3.
    write(3, 7, -7);
    write(3, 9, -9);
    for (int j = 0; j < 16; j++)
      if (brev[j] != 3) write(brev[j], brev[j] * 100, -brev[j]);
    push_frame(0, 1'b1, 1'b1);
    idle(1);
    wait_drain();
    chk("dup_err", {bus.dup_err_o, bus.drop_err_o}, 64'b10);

    // Input during drain, then back-to-back frames.
    fill_frame(0, 1'b1);
    idle(3);
    write(0, 999, 999);
    idle(1);
    wait_done();
    fill_frame(7, 1'b1);
    idle(1);
    wait_done();
    fill_frame(11, 1'b1);
    idle(1);
    wait_drain();
    chk("drop_err", {bus.dup_err_o, bus.drop_err_o}, 64'b11);

    // Reset mid-drain after six beats.
    beat_cnt = 0;
    fill_frame(0, 1'b0);
    idle(1);
    n = 0;
    while (beat_cnt < 6 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (n >= 100) chk("beat6_timeout", 64'(beat_cnt), 64'd6);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_outputs("reset_mid_drain");
    exp_q.delete();
    expect_done = 1'b0;
    rst = 1'b0;
    fill_frame(0, 1'b1);
    idle(1);
    wait_drain();

    // Reset mid-fill: ten stale bins must not count toward the next frame.
    for (int j = 0; j < 10; j++) write(brev[j], 5000 + brev[j], 5000);
    idle(1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fill_frame(3, 1'b1);
    idle(1);
    wait_drain();
    chk("errs_after_reset", {bus.dup_err_o, bus.drop_err_o}, 64'd0);

    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_output_reorder.md
# fft_output_reorder

Collects the scattered results of the last FFT butterfly stage into an N-entry buffer, each at the bin index that stage supplies with the sample. Once all N bins of a frame are present, streams them out in natural bin order (0..N-1) over a valid/ready interface. The downstream consumer, for example the UART transmit path, may stall that interface freely. Sits directly downstream of the final radix-2 stage and absorbs its out-of-order, unthrottled output.

## Interface
- bit_width, 24, width of Re/Im samples (two's complement)
- N, 16, FFT length = buffer depth
- SIZE, 4, log2(N), bin index width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high (codebase stem `rst`; no `_n` because polarity is fixed high)
- valid_i  in  1  input sample strobe from final stage (no backpressure upstream)
- Re_i  in  bit_width  real part
- Im_i  in  bit_width  imaginary part
- wr_ptr_i  in  SIZE  bin index of the input sample
- valid_o  out  1  output sample valid
- ready_i  in  1  downstream accepts the output sample
- Re_o  out  bit_width  real part, natural order
- Im_o  out  bit_width  imaginary part
- idx_o  out  SIZE  bin index of the output sample
- last_o  out  1  high with bin N-1
- frame_done_o  out  1  one-cycle pulse after the last beat is accepted
- dup_err_o  out  1  sticky: a bin was written twice within one frame
- drop_err_o  out  1  sticky: valid_i arrived during drain and was discarded

## Operation
- Storage: N×(2·bit_width) register array, plus an N-bit `filled` bitmap and a SIZE+1-bit `fill_cnt`.
- FSM has two states.
- FILL (reset state):
  - On valid_i, write mem[wr_ptr_i] <= {Re_i, Im_i}.
  - If filled[wr_ptr_i]=0: set it and increment fill_cnt.
  - Otherwise: overwrite the data, leave fill_cnt unchanged, set dup_err_o.
  - When the write makes fill_cnt = N: go to DRAIN and set rd_ptr = 0.
- DRAIN:
  - Output register loads {mem[rd_ptr], rd_ptr} when (!valid_o || ready_i) and rd_ptr ≤ N-1; valid_o <= 1, then rd_ptr increments.
  - The beat is accepted when valid_o && ready_i.
  - If no new load occurs on an accepting cycle, valid_o <= 0.
  - When the beat with idx N-1 is accepted: pulse frame_done_o, clear filled and fill_cnt, go to FILL.
- valid_i during DRAIN (including the final acceptance cycle): the sample is dropped, drop_err_o is set, and no state changes. The first cycle back in FILL accepts input normally.
- Output data is held stable while valid_o && !ready_i.
- Error flags clear only on rst.
- No arithmetic. Data passes through bit-exact; SIZE must equal log2(N).

## Timing
- Reset values: valid_o=0, Re_o=0, Im_o=0, idx_o=0, last_o=0, frame_done_o=0, dup_err_o=0, drop_err_o=0; state FILL, buffer bitmap cleared. Memory contents are don't-care.
- rst asserted mid-frame or mid-drain aborts the frame. The next cycle is FILL with an empty buffer.
- The N-th unique write in cycle T puts the FSM in DRAIN at T+1; the first valid_o is at T+2.
- With ready_i held high: one beat per cycle, N consecutive beats, last_o on beat N. frame_done_o is high the cycle after the last acceptance, and FILL is active that same cycle.
- Throughput: a frame occupies ≥ N fill cycles + N+1 drain cycles.

## Structure
- Shared package: FSM state enum (FILL, DRAIN) and a packed complex-sample struct {Re, Im} parameterised by bit_width. Reuse the one the stage modules use if it exists.
- One natural sub-module: `out_skid_reg`, a single-entry valid/ready output register holding data, idx and last.
- Remaining logic stays in the top: bitmap, counter, FSM, memory.

## Test plan
- Bit-reversed fill, N=16: write bin k = bitrev(j) with Re=k·100, Im=-k for j=0..15, ready_i=1. Expect 16 consecutive beats idx 0..15, Re 0,100..1500, last_o on idx 15, frame_done_o one cycle later, no errors.
- Backpressure: same frame, ready_i toggling 1,0,0,1,… Expect every beat held stable while stalled, order unchanged, no duplicates or skips.
- Duplicate write: write bin 3 twice (values 7 then 9), then the other 15 bins. Expect dup_err_o=1, drain starts only after 16 unique bins, idx 3 outputs Re=9.
- Input during drain: assert valid_i on the 5th drain cycle. Expect drop_err_o=1 and drained data unaffected; two back-to-back frames then both drain correctly.
- Reset mid-drain: assert rst after 6 beats. Expect all outputs at reset values next cycle; a fresh full frame then drains 0..15 correctly.
- Reset mid-fill: 10 bins written, rst, then 16 new bins. Expect drain only after the 16 new writes, with new values only.
